// File: rtl/addsub_nibble_serial_if.sv
// Operand/result handshake bundle for the nibble-serial add/sub unit.
// The slave modport is the unit; the master is the controller/consumer side.
interface addsub_nibble_serial_if #(parameter int NIBBLES = 4);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*NIBBLES-1:0] a;
  logic [4*NIBBLES-1:0] b;
  logic                 sign;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*NIBBLES:0]   s;
  logic                 ovf;
  logic                 zero;

  modport slave (
    input  in_valid, a, b, sign, out_ready,
    output in_ready, out_valid, s, ovf, zero
  );

  modport master (
    output in_valid, a, b, sign, out_ready,
    input  in_ready, out_valid, s, ovf, zero
  );
endinterface

// File: rtl/addsub_nibble_serial.sv
// Nibble-serial W-bit add/subtract: one 4-bit slice, one nibble per clock, registered carry.
// Result appears NIBBLES cycles after accept and is held on out_valid until out_ready.
module addsub_nibble_serial #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  addsub_nibble_serial_if.slave  io
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           sign_q, sign_d;
  logic [W:0]     s_q, s_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;
  logic           out_valid_q, out_valid_d;

  logic [KW+1:0]  idx;
  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [4:0]     sum;
  logic [3:0]     low3;

  always_comb begin
    idx   = {k_q, 2'b00};
    a_nib = a_q[idx +: 4];
    b_nib = b_q[idx +: 4] ^ {4{sign_q}};
    sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    // bit 3 here is the carry into the nibble's top bit, needed for overflow
    low3  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_q};

    state_d     = state_q;
    k_d         = k_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    s_d         = s_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.b;
          sign_d  = io.sign;
          carry_d = io.sign;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx +: 4] = sum[3:0];
        carry_d       = sum[4];
        if (k_q == K_LAST) begin
          s_d[W]      = sum[4];
          ovf_d       = low3[3] ^ sum[4];
          zero_d      = (s_d[W-1:0] == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      s_q         <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      s_q         <= s_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.s         = s_q;
  assign io.ovf       = ovf_q;
  assign io.zero      = zero_q;
endmodule

// File: tb/tb_addsub_nibble_serial.sv
// Scoreboard bench: the driver pushes hand-computed results, a negedge monitor pops on handshake.
module tb_addsub_nibble_serial;
  localparam int NIB = 4;

  typedef struct {
    logic [16:0] s;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   pass;
  int   cyc;
  int   last_accept;
  exp_t sb[$];

  addsub_nibble_serial_if #(.NIBBLES(NIB)) io();

  addsub_nibble_serial #(.NIBBLES(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                      input logic [16:0] es, input logic eovf, input logic ezero,
                      input bit push, output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(io.in_ready), 32'd1);
    io.a = a;
    io.b = b;
    io.sign = sgn;
    io.in_valid = 1'b1;
    acc = cyc + 1;
    last_accept = acc;
    if (push) begin
      e.s = es;
      e.ovf = eovf;
      e.zero = ezero;
      sb.push_back(e);
    end
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || io.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: samples mid-cycle so out_ready reflects the value seen at the next edge
  initial begin
    logic prev_valid;
    logic prev_hs;
    exp_t e;
    prev_valid = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (prev_hs) chk("valid_one_cycle", 32'(io.out_valid), 32'd0);
        if (io.out_valid && !prev_valid)
          chk("latency", 32'(cyc - last_accept), 32'(NIB));
        prev_hs = io.out_valid && io.out_ready;
        if (prev_hs) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 32'(io.s), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("s", 32'(io.s), 32'(e.s));
            chk("ovf", 32'(io.ovf), 32'(e.ovf));
            chk("zero", 32'(io.zero), 32'(e.zero));
          end
        end
        prev_valid = io.out_valid;
      end else begin
        prev_valid = 1'b0;
        prev_hs = 1'b0;
      end
    end
  end

  initial begin
    int t0;
    int t1;
    int n;
    total = 0;
    pass = 0;
    cyc = 0;
    last_accept = 0;
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    io.a = '0;
    io.b = '0;
    io.sign = 1'b0;
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_s", 32'(io.s), 32'd0);
    chk("rst_ovf", 32'(io.ovf), 32'd0);
    chk("rst_zero", 32'(io.zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(16'h1234, 16'h0FFF, 1'b0, 17'h02233, 1'b0, 1'b0, 1'b1, t0);
    send(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, 1'b1, 1'b1, t0);
    send(16'h0005, 16'h0007, 1'b1, 17'h0FFFE, 1'b0, 1'b0, 1'b1, t0);
    send(16'h8000, 16'h0001, 1'b1, 17'h17FFF, 1'b1, 1'b0, 1'b1, t0);
    send(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, 1'b0, 1'b1, t1);
    chk("min_period", 32'(t1 - t0), 32'(NIB + 2));
    send(16'h0000, 16'h0000, 1'b1, 17'h10000, 1'b0, 1'b1, 1'b1, t0);
    drain();

    // Backpressure: result must hold while a competing operand is offered
    io.out_ready = 1'b0;
    send(16'h00FF, 16'h0F01, 1'b0, 17'h01000, 1'b0, 1'b0, 1'b1, t0);
    n = 0;
    while (!io.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("out_valid_timeout", 32'(io.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      io.a = 16'hAAAA;
      io.b = 16'h5555;
      io.sign = 1'b0;
      io.in_valid = 1'b1;
      #1;
      chk("hold_valid", 32'(io.out_valid), 32'd1);
      chk("hold_s", 32'(io.s), 32'h01000);
      chk("hold_ovf", 32'(io.ovf), 32'd0);
      chk("hold_zero", 32'(io.zero), 32'd0);
      chk("hold_in_ready", 32'(io.in_ready), 32'd0);
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("release_valid", 32'(io.out_valid), 32'd0);
    chk("release_in_ready", 32'(io.in_ready), 32'd1);
    send(16'h0003, 16'h0004, 1'b1, 17'h0FFFF, 1'b0, 1'b0, 1'b1, t0);
    drain();

    // Reset after E2 aborts the transaction; nothing is pushed for it
    send(16'h1111, 16'h2222, 1'b0, 17'h0, 1'b0, 1'b0, 1'b0, t0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(io.out_valid), 32'd0);
    chk("abort_s", 32'(io.s), 32'd0);
    chk("abort_in_ready", 32'(io.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #2;
      chk("no_partial", 32'(io.out_valid), 32'd0);
    end
    send(16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b0, 1'b0, 1'b1, t0);
    drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
